// File: rtl/condicionador_botao_if.sv
// condicionador_botao_if: raw button inputs and conditioned outputs between board pins and the consumer FSM
interface condicionador_botao_if #(
  parameter int N_BOTOES = 4
);
  logic [N_BOTOES-1:0] botao;
  logic                repete_en;
  logic [N_BOTOES-1:0] nivel;
  logic [N_BOTOES-1:0] pulso;
  modport master (output botao, repete_en, input nivel, pulso);
  modport slave (input botao, repete_en, output nivel, pulso);
endinterface

// File: rtl/condicionador_botao.sv
// condicionador_botao: synchronises, debounces and auto-repeats N active-low push-buttons
module condicionador_botao #(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int REPEAT_ATRASO   = 25000000,
  parameter int REPEAT_PERIODO  = 5000000
) (
  input logic                  clock,
  input logic                  reset_n,
  condicionador_botao_if.slave bus
);
  localparam int MAX_DA = DEBOUNCE_CICLOS > REPEAT_ATRASO ? DEBOUNCE_CICLOS : REPEAT_ATRASO;
  localparam int MAXC   = MAX_DA > REPEAT_PERIODO ? MAX_DA : REPEAT_PERIODO;
  localparam int W      = $clog2(MAXC) + 1;
  localparam logic [W-1:0] DEB_FIM = W'(DEBOUNCE_CICLOS - 1);
  localparam logic [W-1:0] ATR_FIM = W'(REPEAT_ATRASO - 1);
  localparam logic [W-1:0] PER_FIM = W'(REPEAT_PERIODO - 1);

  typedef enum logic [1:0] {SOLTO, CONFIRMA_PRESS, PRESSIONADO, CONFIRMA_SOLTA} estado_t;

  estado_t             est_q [N_BOTOES];
  estado_t             est_d [N_BOTOES];
  logic [W-1:0]        cnt_q [N_BOTOES];
  logic [W-1:0]        cnt_d [N_BOTOES];
  logic [W-1:0]        rpt_q [N_BOTOES];
  logic [W-1:0]        rpt_d [N_BOTOES];
  logic [N_BOTOES-1:0] s1, s2, fase_q, fase_d, nivel_q, nivel_d, pulso_q, pulso_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '1;
      s2      <= '1;
      fase_q  <= '0;
      nivel_q <= '0;
      pulso_q <= '0;
      for (int i = 0; i < N_BOTOES; i++) begin
        est_q[i] <= SOLTO;
        cnt_q[i] <= '0;
        rpt_q[i] <= '0;
      end
    end else begin
      s1      <= bus.botao;
      s2      <= s1;
      fase_q  <= fase_d;
      nivel_q <= nivel_d;
      pulso_q <= pulso_d;
      for (int i = 0; i < N_BOTOES; i++) begin
        est_q[i] <= est_d[i];
        cnt_q[i] <= cnt_d[i];
        rpt_q[i] <= rpt_d[i];
      end
    end
  end

  // fase=0 waits for the initial repeat delay, fase=1 for the shorter period
  always_comb begin
    fase_d  = '0;
    nivel_d = nivel_q;
    pulso_d = '0;
    for (int i = 0; i < N_BOTOES; i++) begin
      est_d[i] = est_q[i];
      cnt_d[i] = cnt_q[i];
      rpt_d[i] = '0;
      unique case (est_q[i])
        SOLTO: begin
          est_d[i] = s2[i] ? SOLTO : CONFIRMA_PRESS;
          cnt_d[i] = s2[i] ? W'(0) : W'(1);
        end
        CONFIRMA_PRESS: begin
          if (s2[i]) begin
            est_d[i] = SOLTO;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DEB_FIM) begin
            est_d[i]   = PRESSIONADO;
            nivel_d[i] = 1'b1;
            pulso_d[i] = 1'b1;
            cnt_d[i]   = '0;
          end else cnt_d[i] = cnt_q[i] + 1'b1;
        end
        PRESSIONADO: begin
          if (s2[i]) begin
            est_d[i] = CONFIRMA_SOLTA;
            cnt_d[i] = W'(1);
          end else if (bus.repete_en) begin
            pulso_d[i] = rpt_q[i] == (fase_q[i] ? PER_FIM : ATR_FIM);
            rpt_d[i]   = pulso_d[i] ? '0 : rpt_q[i] + 1'b1;
            fase_d[i]  = fase_q[i] | pulso_d[i];
          end
        end
        CONFIRMA_SOLTA: begin
          if (!s2[i]) begin
            est_d[i] = PRESSIONADO;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DEB_FIM) begin
            est_d[i]   = SOLTO;
            nivel_d[i] = 1'b0;
            cnt_d[i]   = '0;
          end else cnt_d[i] = cnt_q[i] + 1'b1;
        end
        default: est_d[i] = SOLTO;
      endcase
    end
  end

  assign bus.nivel = nivel_q;
  assign bus.pulso = pulso_q;

  // a repeat period of 1 would pulse on consecutive cycles
  assert property (@(posedge clock) disable iff (!reset_n) (pulso_q & pulso_d) == '0)
    else $error("condicionador_botao: pulso high on consecutive cycles");
endmodule

// File: tb/tb_condicionador_botao.sv
// tb_condicionador_botao: directed scenarios plus random stimulus against a run-length reference model
module tb_condicionador_botao;
  localparam int N = 4, D = 4, ATR = 10, PER = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  condicionador_botao_if #(.N_BOTOES(N)) bus ();

  condicionador_botao #(
    .N_BOTOES(N), .DEBOUNCE_CICLOS(D), .REPEAT_ATRASO(ATR), .REPEAT_PERIODO(PER)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int passed = 0, total = 0;
  int pc [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference: each edge sees the raw input from two edges earlier; the level flips
  // once D consecutive samples disagree with it; held time drives repeat pulses.
  logic [N-1:0] m_h1 = '1, m_h2 = '1, m_prev = '1, m_nivel = '0, m_pulso = '0;
  int m_run [N] = '{default: 0};
  int m_hold [N] = '{default: 0};
  logic pr;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_h1 = '1; m_h2 = '1; m_prev = '1; m_nivel = '0; m_pulso = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0;
        m_hold[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        pr = !m_h2[i];
        m_run[i] = (m_h2[i] == m_prev[i]) ? m_run[i] + 1 : 1;
        m_pulso[i] = 1'b0;
        if (m_nivel[i] && pr && !m_prev[i] && bus.repete_en) m_hold[i] = m_hold[i] + 1;
        else m_hold[i] = 0;
        if (m_hold[i] >= ATR && (m_hold[i] - ATR) % PER == 0) m_pulso[i] = 1'b1;
        if (pr != m_nivel[i] && m_run[i] >= D) begin
          m_nivel[i] = pr;
          m_pulso[i] = pr;
          m_hold[i] = 0;
        end
        m_prev[i] = m_h2[i];
      end
      m_h2 = m_h1;
      m_h1 = bus.botao;
    end
  end

  task automatic step();
    @(negedge clock);
    chk("nivel", 32'(bus.nivel), 32'(m_nivel));
    chk("pulso", 32'(bus.pulso), 32'(m_pulso));
    for (int i = 0; i < N; i++) pc[i] += int'(bus.pulso[i]);
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) pc[i] = 0;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int lat;

  initial begin
    bus.botao = '1;
    bus.repete_en = 1'b0;
    clr();
    #1 reset_n = 1'b0;
    steps(3);
    chk("reset_nivel", 32'(bus.nivel), 0);
    chk("reset_pulso", 32'(bus.pulso), 0);
    reset_n = 1'b1;
    steps(3);

    // clean press and release
    bus.botao[0] = 1'b0; lat = 0; clr();
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.pulso[0] && lat == 0) lat = k;
    end
    chk("t1_press_lat", lat, 6);
    chk("t1_npulse", pc[0], 1);
    chk("t1_nivel", 32'(bus.nivel[0]), 1);
    bus.botao[0] = 1'b1; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (!bus.nivel[0] && lat == 0) lat = k;
    end
    chk("t1_release_lat", lat, 6);

    // bounce shorter than the debounce window
    clr();
    bus.botao[1] = 1'b0; steps(3);
    bus.botao[1] = 1'b1; steps(1);
    bus.botao[1] = 1'b0; steps(3);
    bus.botao[1] = 1'b1; steps(10);
    chk("t2_npulse", pc[1], 0);
    chk("t2_nivel", 32'(bus.nivel[1]), 0);

    // auto-repeat
    bus.repete_en = 1'b1;
    bus.botao[2] = 1'b0; lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step();
      if (bus.pulso[2]) lat = k;
    end
    chk("t3_accept", lat, 6);
    clr();
    steps(30);
    bus.botao[2] = 1'b1;
    steps(20);
    chk("t3_repeats", pc[2], 5);
    bus.repete_en = 1'b0;

    // simultaneous press
    bus.botao = 4'b0000; lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      step();
      if (bus.pulso != 0) begin
        lat = k;
        chk("t4_pulso_all", 32'(bus.pulso), 32'hf);
      end
    end
    chk("t4_lat", lat, 6);
    clr(); steps(10);
    chk("t4_no_more", pc[0] + pc[1] + pc[2] + pc[3], 0);
    bus.botao = '1; steps(10);

    // reset during CONFIRMA_PRESS, then during PRESSIONADO
    for (int r = 0; r < 2; r++) begin
      bus.botao[0] = 1'b0;
      steps(r == 0 ? 3 : 12);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_nivel", 32'(bus.nivel), 0);
      chk("t5_rst_pulso", 32'(bus.pulso), 0);
      step();
      reset_n = 1'b1; lat = 0; clr();
      for (int k = 1; k <= 15; k++) begin
        step();
        if (bus.pulso[0] && lat == 0) lat = k;
      end
      chk("t5_fresh_lat", lat, 6);
      chk("t5_fresh_count", pc[0], 1);
    end

    // release bounce while pressed
    clr();
    bus.botao[0] = 1'b1; steps(2);
    bus.botao[0] = 1'b0; steps(15);
    chk("t6_nivel", 32'(bus.nivel[0]), 1);
    chk("t6_npulse", pc[0], 0);
    bus.botao = '1; steps(10);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) bus.botao[i] = ~bus.botao[i];
      if ($urandom_range(0, 60) == 0) bus.repete_en = ~bus.repete_en;
      if ($urandom_range(0, 500) == 0) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 40) == 0) begin
        bus.botao = 4'($urandom);
        steps(int'($urandom_range(10, 40)));
      end else step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
